// File: rtl/ttt_pkg.sv
// Shared types for the tic-tac-toe sequencer: FSM states, winner codes, line masks.
// Cell bit 0 = a (top-left) ... bit 8 = i (bottom-right), row-major.
package ttt_pkg;

  typedef enum logic [1:0] {
    S_X    = 2'd0,
    S_O    = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_X    = 2'b01;
  localparam logic [1:0] WIN_O    = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int NUM_LINES = 8;

  // rows, columns, then the two diagonals
  localparam logic [8:0] LINE_MASK [NUM_LINES] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  function automatic logic is_onehot(input logic [8:0] v);
    return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
  endfunction

  // Isolates the lowest zero bit of the occupancy vector.
  function automatic logic [8:0] lowest_empty(input logic [8:0] occ);
    logic [8:0] free;
    free = ~occ;
    return free & (~free + 9'd1);
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational three-in-a-row detector over one player's board; zero latency, no flow control.
module ttt_line_check
  import ttt_pkg::*;
(
  input  logic [8:0] board,
  output logic       has_line
);

  always_comb begin
    has_line = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if ((board & LINE_MASK[i]) == LINE_MASK[i]) has_line = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe turn FSM: accepts one legal move per turn, evaluates one cycle later.
// Illegal or out-of-turn moves are dropped; a silent AI gets a fallback O after AI_TIMEOUT cycles.
module ttt_turn_sequencer
  import ttt_pkg::*;
#(
  parameter int AI_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       game_mode,
  input  logic       new_game,
  input  logic [8:0] btn_in,
  input  logic       ai_move_valid,
  input  logic [8:0] ai_move,
  output logic       ai_req,
  output logic       p1_turn,
  output logic [8:0] board_x,
  output logic [8:0] board_o,
  output logic [1:0] winner,
  output logic       game_over,
  output logic [3:0] move_count
);

  localparam logic [7:0] TMO_LAST = 8'(AI_TIMEOUT - 1);

  state_t     state;
  logic       mode_q;
  logic       o_moved;
  logic [7:0] tmo_cnt;

  logic       ai_turn;
  logic [8:0] cand;
  logic [8:0] occupied;
  logic       move_ok;
  logic       timeout_hit;
  logic       take;
  logic [8:0] place;
  logic [8:0] mover_board;
  logic       mover_has_line;

  assign ai_turn  = (state == S_O) && mode_q;
  assign occupied = board_x | board_o;

  always_comb begin
    cand = 9'd0;
    case (state)
      S_X:     cand = btn_in;
      S_O:     cand = mode_q ? (ai_move_valid ? ai_move : 9'd0) : btn_in;
      default: cand = 9'd0;
    endcase
  end

  assign move_ok     = is_onehot(cand) && ((cand & occupied) == 9'd0);
  assign timeout_hit = ai_turn && !move_ok && (tmo_cnt == TMO_LAST);
  assign take        = move_ok || timeout_hit;
  assign place       = move_ok ? cand : lowest_empty(occupied);

  // Only the player who just moved can have completed a line.
  assign mover_board = o_moved ? board_o : board_x;

  ttt_line_check u_line_check (
    .board    (mover_board),
    .has_line (mover_has_line)
  );

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state      <= S_X;
      mode_q     <= game_mode;
      o_moved    <= 1'b0;
      tmo_cnt    <= 8'd0;
      board_x    <= 9'd0;
      board_o    <= 9'd0;
      winner     <= WIN_NONE;
      move_count <= 4'd0;
    end else begin
      case (state)
        S_X, S_O: begin
          if (take) begin
            if (state == S_O) begin
              board_o <= board_o | place;
              o_moved <= 1'b1;
            end else begin
              board_x <= board_x | place;
              o_moved <= 1'b0;
            end
            move_count <= move_count + 4'd1;
            state      <= S_EVAL;
          end else if (ai_turn) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_EVAL: begin
          if (mover_has_line) begin
            winner <= o_moved ? WIN_O : WIN_X;
            state  <= S_DONE;
          end else if (move_count == 4'd9) begin
            winner <= WIN_DRAW;
            state  <= S_DONE;
          end else begin
            state   <= o_moved ? S_X : S_O;
            tmo_cnt <= 8'd0;
          end
        end
        S_DONE: state <= S_DONE;
        default: state <= S_X;
      endcase
    end
  end

  assign p1_turn   = (state == S_X);
  assign ai_req    = ai_turn;
  assign game_over = (state == S_DONE);

endmodule
